// File: rtl/phv_link_fifo_if.sv
// PHV link bundle between match-action stage N, the elastic buffer and stage N+1.
// Modport master drives PHVs in and observes status; slave is the buffer's view.
interface phv_link_fifo_if #(
    parameter int PHV_LEN = 1124,
    parameter int CNT_W   = 4
);
    logic [PHV_LEN-1:0] phv_in;
    logic               phv_in_valid;
    logic               flush;
    logic               next_stg_ready;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_out_valid;
    logic [CNT_W-1:0]   count;
    logic               empty;
    logic               full;
    logic               almost_full;
    logic               drop_pulse;
    logic [15:0]        drop_cnt;
    logic [CNT_W-1:0]   peak_count;

    modport master (
        output phv_in, phv_in_valid, flush, next_stg_ready,
        input  phv_out, phv_out_valid, count, empty, full, almost_full,
               drop_pulse, drop_cnt, peak_count
    );

    modport slave (
        input  phv_in, phv_in_valid, flush, next_stg_ready,
        output phv_out, phv_out_valid, count, empty, full, almost_full,
               drop_pulse, drop_cnt, peak_count
    );
endinterface

// File: rtl/phv_link_fifo.sv
// Elastic DEPTH-entry PHV buffer between two match-action stages; optional stats via PHV_LINK_STATS_EN.
// Latency: PHV in at cycle t appears on phv_out_valid at t+2 (registered read, no bypass).
// Backpressure: pops only while next_stg_ready; input cannot be stalled, so overflow drops and pulses drop_pulse.
module phv_link_fifo #(
    parameter int PHV_LEN      = 1124,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6,
    parameter int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic           axis_clk,
    input  logic           areset,
    phv_link_fifo_if.slave link
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PHV_LEN-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_nxt;
    logic               empty_q;
    logic               full_q;
    logic               afull_q;
    logic               drop_q;
    logic [PHV_LEN-1:0] out_q;
    logic               out_vld_q;
    logic               pop;
    logic               push;
    logic               drop;

    // Flags are registered, so the conditions below see last edge's occupancy.
    assign pop  = !empty_q && link.next_stg_ready && !link.flush;
    assign push = link.phv_in_valid && !link.flush && (!full_q || pop);
    assign drop = link.phv_in_valid && full_q && !pop && !link.flush;

    always_comb begin
        count_nxt = count_q;
        if (link.flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count_q - CNT_W'(1);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem[wr_ptr] <= link.phv_in;
        end
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            drop_q    <= 1'b0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            count_q   <= count_nxt;
            empty_q   <= (count_nxt == '0);
            full_q    <= (count_nxt == CNT_W'(DEPTH));
            afull_q   <= (count_nxt >= CNT_W'(AFULL_THRESH));
            drop_q    <= drop;
            out_vld_q <= pop;
            if (link.flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop) begin
                    out_q  <= mem[rd_ptr];
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end
        end
    end

    assign link.phv_out       = out_q;
    assign link.phv_out_valid = out_vld_q;
    assign link.count         = count_q;
    assign link.empty         = empty_q;
    assign link.full          = full_q;
    assign link.almost_full   = afull_q;
    assign link.drop_pulse    = drop_q;

`ifdef PHV_LINK_STATS_EN
    logic [15:0]      drop_cnt_q;
    logic [CNT_W-1:0] peak_q;

    // Stats survive flush so overflow history is visible across pipeline clears.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            drop_cnt_q <= '0;
            peak_q     <= '0;
        end else begin
            if (drop && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (count_nxt > peak_q) begin
                peak_q <= count_nxt;
            end
        end
    end

    assign link.drop_cnt   = drop_cnt_q;
    assign link.peak_count = peak_q;
`else
    assign link.drop_cnt   = '0;
    assign link.peak_count = '0;
`endif
endmodule

// File: tb/tb_phv_link_fifo.sv
// Randomized bench for phv_link_fifo against a queue-based reference model.
module tb_phv_link_fifo;
    localparam int PHV_LEN      = 1124;
    localparam int DEPTH        = 8;
    localparam int AFULL_THRESH = 6;
    localparam int CNT_W        = 4;
`ifdef PHV_LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    phv_link_fifo_if #(.PHV_LEN(PHV_LEN), .CNT_W(CNT_W)) link();

    phv_link_fifo #(
        .PHV_LEN(PHV_LEN), .DEPTH(DEPTH), .AFULL_THRESH(AFULL_THRESH), .CNT_W(CNT_W)
    ) dut (
        .axis_clk(clk),
        .areset  (rst),
        .link    (link.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [PHV_LEN-1:0] mq [$];
    logic [PHV_LEN-1:0] exp_out;
    logic               exp_vld;
    logic               exp_drop;
    int                 exp_dcnt;
    int                 exp_peak;

    function automatic logic [PHV_LEN-1:0] rnd_phv();
        logic [PHV_LEN-1:0] v;
        for (int i = 0; i < PHV_LEN; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic logic [PHV_LEN-1:0] byte_phv(input logic [7:0] b);
        logic [PHV_LEN-1:0] v;
        for (int i = 0; i < PHV_LEN; i++) v[i] = b[i % 8];
        return v;
    endfunction

    function automatic logic [15:0] want_dcnt();
        return STATS ? 16'(exp_dcnt) : 16'd0;
    endfunction

    function automatic logic [CNT_W-1:0] want_peak();
        return STATS ? CNT_W'(exp_peak) : '0;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_out  = '0;
        exp_vld  = 1'b0;
        exp_drop = 1'b0;
        exp_dcnt = 0;
        exp_peak = 0;
    endtask

    // Drives one cycle of inputs, advances the model, and returns #1 after the edge.
    task automatic cycle(input logic vld, input logic [PHV_LEN-1:0] d,
                         input logic rdy, input logic fl);
        link.phv_in_valid   = vld;
        link.phv_in         = d;
        link.next_stg_ready = rdy;
        link.flush          = fl;
        exp_vld  = 1'b0;
        exp_drop = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && rdy) begin
                exp_out = mq.pop_front();
                exp_vld = 1'b1;
            end
            if (vld) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else begin
                    exp_drop = 1'b1;
                    if (exp_dcnt < 65535) exp_dcnt++;
                end
            end
        end
        if (mq.size() > exp_peak) exp_peak = mq.size();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        link.phv_in_valid = 1'b0; link.phv_in = '0; link.next_stg_ready = 1'b0; link.flush = 1'b0;
        model_reset();
        @(posedge clk); #1;
        n_cmp++; if (link.phv_out !== '0) begin n_bad++; $display("FAIL reset_phv_out got %0h want 0", link.phv_out[31:0]); end
        n_cmp++; if (link.phv_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", link.phv_out_valid); end
        n_cmp++; if (link.count !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", link.count); end
        n_cmp++; if ({link.empty, link.full, link.almost_full, link.drop_pulse} !== 4'b1000) begin
            n_bad++; $display("FAIL reset_flags got %b want 1000", {link.empty, link.full, link.almost_full, link.drop_pulse}); end
        n_cmp++; if (link.drop_cnt !== 16'd0 || link.peak_count !== '0) begin
            n_bad++; $display("FAIL reset_stats got %0d/%0d want 0/0", link.drop_cnt, link.peak_count); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [PHV_LEN-1:0] a5;
        a5 = byte_phv(8'hA5);
        cycle(1'b1, a5, 1'b1, 1'b0);
        n_cmp++; if (link.phv_out_valid !== 1'b0) begin n_bad++; $display("FAIL single_t1_valid got %b want 0", link.phv_out_valid); end
        n_cmp++; if (link.count !== CNT_W'(1)) begin n_bad++; $display("FAIL single_t1_count got %0d want 1", link.count); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (link.phv_out_valid !== 1'b1) begin n_bad++; $display("FAIL single_t2_valid got %b want 1", link.phv_out_valid); end
        n_cmp++; if (link.phv_out !== a5) begin n_bad++; $display("FAIL single_t2_data got %0h want %0h", link.phv_out[31:0], a5[31:0]); end
        n_cmp++; if (link.count !== '0 || link.empty !== 1'b1) begin
            n_bad++; $display("FAIL single_drained got count %0d empty %b want 0/1", link.count, link.empty); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (link.phv_out_valid !== 1'b0 || link.phv_out !== a5) begin
            n_bad++; $display("FAIL single_hold got valid %b data %0h want 0/%0h", link.phv_out_valid, link.phv_out[31:0], a5[31:0]); end
    endtask

    task automatic test_fill_and_drop();
        for (int k = 1; k <= DEPTH; k++) begin
            cycle(1'b1, rnd_phv(), 1'b0, 1'b0);
            n_cmp++; if (link.count !== CNT_W'(k) || link.almost_full !== (k >= AFULL_THRESH)) begin
                n_bad++; $display("FAIL fill_%0d got count %0d afull %b want %0d/%b", k, link.count, link.almost_full, k, k >= AFULL_THRESH); end
        end
        n_cmp++; if (link.full !== 1'b1) begin n_bad++; $display("FAIL fill_full got %b want 1", link.full); end
        cycle(1'b1, rnd_phv(), 1'b0, 1'b0);
        n_cmp++; if (link.drop_pulse !== 1'b1 || link.count !== CNT_W'(DEPTH)) begin
            n_bad++; $display("FAIL drop got pulse %b count %0d want 1/%0d", link.drop_pulse, link.count, DEPTH); end
        n_cmp++; if (link.drop_cnt !== (STATS ? 16'd1 : 16'd0) || link.peak_count !== (STATS ? CNT_W'(DEPTH) : CNT_W'(0))) begin
            n_bad++; $display("FAIL drop_stats got %0d/%0d want %0d/%0d", link.drop_cnt, link.peak_count, want_dcnt(), want_peak()); end
        cycle(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (link.drop_pulse !== 1'b0) begin n_bad++; $display("FAIL drop_once got %b want 0", link.drop_pulse); end
    endtask

    task automatic test_full_pass();
        cycle(1'b1, rnd_phv(), 1'b1, 1'b0);
        n_cmp++; if (link.drop_pulse !== 1'b0 || link.count !== CNT_W'(DEPTH) || link.phv_out_valid !== 1'b1) begin
            n_bad++; $display("FAIL full_pass got drop %b count %0d valid %b want 0/%0d/1", link.drop_pulse, link.count, link.phv_out_valid, DEPTH); end
        n_cmp++; if (link.phv_out !== exp_out) begin n_bad++; $display("FAIL full_pass_data got %0h want %0h", link.phv_out[31:0], exp_out[31:0]); end
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            n_cmp++; if (link.phv_out_valid !== 1'b1 || link.phv_out !== exp_out) begin
                n_bad++; $display("FAIL drain_%0d got valid %b data %0h want 1/%0h", k, link.phv_out_valid, link.phv_out[31:0], exp_out[31:0]); end
        end
        n_cmp++; if (link.empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty got %b want 1", link.empty); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++) cycle(1'b1, rnd_phv(), 1'b0, 1'b0);
        cycle(1'b1, rnd_phv(), 1'b1, 1'b1);
        n_cmp++; if (link.count !== '0 || link.empty !== 1'b1 || link.phv_out_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush got count %0d empty %b valid %b want 0/1/0", link.count, link.empty, link.phv_out_valid); end
        n_cmp++; if (link.drop_pulse !== 1'b0 || link.drop_cnt !== want_dcnt()) begin
            n_bad++; $display("FAIL flush_drop got %b/%0d want 0/%0d", link.drop_pulse, link.drop_cnt, want_dcnt()); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (link.phv_out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_after got %b want 0", link.phv_out_valid); end
    endtask

    task automatic test_areset_mid();
        logic [PHV_LEN-1:0] p;
        for (int k = 0; k < 3; k++) cycle(1'b1, rnd_phv(), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (link.phv_out_valid !== 1'b0 || link.phv_out !== '0 || link.count !== '0) begin
            n_bad++; $display("FAIL areset_now got valid %b count %0d want 0/0", link.phv_out_valid, link.count); end
        n_cmp++; if (link.empty !== 1'b1 || link.drop_cnt !== 16'd0 || link.peak_count !== '0) begin
            n_bad++; $display("FAIL areset_state got empty %b stats %0d/%0d want 1/0/0", link.empty, link.drop_cnt, link.peak_count); end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (link.phv_out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_release got %b want 0", link.phv_out_valid); end
        p = rnd_phv();
        cycle(1'b1, p, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (link.phv_out_valid !== 1'b1 || link.phv_out !== p) begin
            n_bad++; $display("FAIL areset_latency got valid %b data %0h want 1/%0h", link.phv_out_valid, link.phv_out[31:0], p[31:0]); end
    endtask

    task automatic test_random();
        int rdy_pct;
        logic vld, rdy, fl;
        for (int c = 0; c < 2000; c++) begin
            if (c % 100 == 0) rdy_pct = $urandom_range(10, 95);
            vld = ($urandom_range(0, 99) < 75);
            rdy = ($urandom_range(0, 99) < rdy_pct);
            fl  = ($urandom_range(0, 99) < 2);
            cycle(vld, vld ? rnd_phv() : '0, rdy, fl);
            n_cmp++; if (link.phv_out_valid !== exp_vld || (exp_vld && link.phv_out !== exp_out)) begin
                n_bad++; $display("FAIL rnd_out c%0d got valid %b data %0h want %b/%0h", c, link.phv_out_valid, link.phv_out[31:0], exp_vld, exp_out[31:0]); end
            n_cmp++; if (link.count !== CNT_W'(mq.size()) || link.empty !== (mq.size() == 0)
                         || link.full !== (mq.size() == DEPTH) || link.almost_full !== (mq.size() >= AFULL_THRESH)) begin
                n_bad++; $display("FAIL rnd_occ c%0d got count %0d e/f/af %b%b%b want %0d", c, link.count, link.empty, link.full, link.almost_full, mq.size()); end
            n_cmp++; if (link.drop_pulse !== exp_drop || link.drop_cnt !== want_dcnt() || link.peak_count !== want_peak()) begin
                n_bad++; $display("FAIL rnd_drop c%0d got %b/%0d/%0d want %b/%0d/%0d", c, link.drop_pulse, link.drop_cnt, link.peak_count, exp_drop, want_dcnt(), want_peak()); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_and_drop();
        test_full_pass();
        test_flush();
        test_areset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
